// File: rtl/data_sync_hs.sv
`default_nettype none
// ============================================================================
// Module      : data_sync_hs
// Description : Synchronizes an asynchronous bus qualifier into the CLK
//               domain, detects level-rise or toggle events, captures the
//               source bus on each accepted event and hands it to a
//               valid/ready consumer. Tracks dropped events and counts
//               accepted captures.
// Revision    : 1.0 - initial release
// ============================================================================
module data_sync_hs #(
  parameter int NUM_STAGES  = 2,
  parameter int BUS_WIDTH   = 8,
  parameter int TOGGLE_MODE = 0,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 bus_enable,
  input  logic [BUS_WIDTH-1:0] unsync_bus,
  input  logic                 sync_ready,
  input  logic                 ovf_clr,
  output logic [BUS_WIDTH-1:0] sync_bus,
  output logic                 sync_valid,
  output logic                 enable_pulse,
  output logic                 overflow,
  output logic [CNT_WIDTH-1:0] event_cnt
);

  logic [NUM_STAGES-1:0] sync_chain_q;
  logic                  prev_en_q;
  logic                  sync_en;
  logic                  event_det;
  logic                  accept;
  logic                  drop;

  logic [BUS_WIDTH-1:0]  sync_bus_q,   sync_bus_d;
  logic                  sync_valid_q, sync_valid_d;
  logic                  enable_pulse_q;
  logic                  overflow_q,   overflow_d;
  logic [CNT_WIDTH-1:0]  event_cnt_q,  event_cnt_d;

  assign sync_en = sync_chain_q[NUM_STAGES-1];

  // Metastability chain plus one history flop for edge detection
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_chain_q <= '0;
      prev_en_q    <= 1'b0;
    end else begin
      sync_chain_q <= {sync_chain_q[NUM_STAGES-2:0], bus_enable};
      prev_en_q    <= sync_en;
    end
  end

  // Event type selected at elaboration: any transition or rising edge only
  generate
    if (TOGGLE_MODE != 0) begin : g_toggle_evt
      assign event_det = sync_en ^ prev_en_q;
    end else begin : g_level_evt
      assign event_det = sync_en & ~prev_en_q;
    end
  endgenerate

  // A held word blocks a new one unless the consumer takes it on this edge
  assign accept = event_det & (~sync_valid_q | sync_ready);
  assign drop   = event_det &  sync_valid_q & ~sync_ready;

  // Next-state for the capture register, handshake, sticky flag and counter
  always_comb begin
    sync_bus_d   = sync_bus_q;
    sync_valid_d = sync_valid_q;
    event_cnt_d  = event_cnt_q;
    overflow_d   = overflow_q;
    if (accept) begin
      sync_bus_d   = unsync_bus;
      sync_valid_d = 1'b1;
      event_cnt_d  = event_cnt_q + CNT_WIDTH'(1);
    end else if (!event_det && sync_valid_q && sync_ready) begin
      sync_valid_d = 1'b0;
    end
    // A drop on the same edge as a clear keeps the flag set
    if (drop) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  // Output registers; reset discards any held data immediately
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_bus_q     <= '0;
      sync_valid_q   <= 1'b0;
      enable_pulse_q <= 1'b0;
      overflow_q     <= 1'b0;
      event_cnt_q    <= '0;
    end else begin
      sync_bus_q     <= sync_bus_d;
      sync_valid_q   <= sync_valid_d;
      enable_pulse_q <= event_det;
      overflow_q     <= overflow_d;
      event_cnt_q    <= event_cnt_d;
    end
  end

  assign sync_bus     = sync_bus_q;
  assign sync_valid   = sync_valid_q;
  assign enable_pulse = enable_pulse_q;
  assign overflow     = overflow_q;
  assign event_cnt    = event_cnt_q;

endmodule
`default_nettype wire
